// File: rtl/gp_writeback_arbiter_if.sv
// Writeback bundle: ALU and load requesters, register-file write port and status.
// The arbiter takes the slave modport; the surrounding pipeline and register file take master.
interface gp_writeback_arbiter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 2
);
  logic                  alu_valid;
  logic [ADDR_WIDTH-1:0] alu_dest;
  logic [DATA_WIDTH-1:0] alu_data;
  logic                  alu_ready;

  logic                  mem_valid;
  logic [ADDR_WIDTH-1:0] mem_dest;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  mem_ready;

  logic                  rf_write_enable;
  logic [ADDR_WIDTH-1:0] rf_store_at;
  logic [DATA_WIDTH-1:0] rf_write_data;
  logic                  rf_write_done;

  logic                  busy;
  logic                  last_grant;
  logic                  timeout_error;

  modport slave (
    input  alu_valid, alu_dest, alu_data,
    input  mem_valid, mem_dest, mem_data,
    input  rf_write_done,
    output alu_ready, mem_ready,
    output rf_write_enable, rf_store_at, rf_write_data,
    output busy, last_grant, timeout_error
  );

  modport master (
    output alu_valid, alu_dest, alu_data,
    output mem_valid, mem_dest, mem_data,
    output rf_write_done,
    input  alu_ready, mem_ready,
    input  rf_write_enable, rf_store_at, rf_write_data,
    input  busy, last_grant, timeout_error
  );
endinterface

// File: rtl/gp_writeback_arbiter.sv
// Round-robin ALU/load arbiter for the register-file write port: accept N, strobe N+1, idle again N+3.
// Ready is combinational and only asserted in IDLE, so both requesters stall while a write is in flight.
module gp_writeback_arbiter #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 2,
  parameter int DONE_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  gp_writeback_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(DONE_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] dest;
    logic [DATA_WIDTH-1:0] data;
  } wb_req_t;

  state_t     state;
  wb_req_t    hold_q;
  logic       write_enable_q;
  logic       last_grant_q;
  logic       timeout_q;
  logic [CNT_W-1:0] cnt_q;

  logic grant_alu;
  logic grant_mem;
  logic alu_ready;
  logic mem_ready;

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (bus.alu_valid && bus.mem_valid) begin
      grant_alu = last_grant_q;
      grant_mem = !last_grant_q;
    end else begin
      grant_alu = bus.alu_valid;
      grant_mem = bus.mem_valid;
    end
    alu_ready = !reset && (state == IDLE) && grant_alu;
    mem_ready = !reset && (state == IDLE) && grant_mem;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      hold_q         <= '0;
      write_enable_q <= 1'b0;
      last_grant_q   <= 1'b1;
      timeout_q      <= 1'b0;
      cnt_q          <= '0;
    end else begin
      case (state)
        IDLE: begin
          write_enable_q <= 1'b0;
          if (bus.alu_valid && alu_ready) begin
            hold_q         <= '{dest: bus.alu_dest, data: bus.alu_data};
            last_grant_q   <= 1'b0;
            write_enable_q <= 1'b1;
            state          <= ISSUE;
          end else if (bus.mem_valid && mem_ready) begin
            hold_q         <= '{dest: bus.mem_dest, data: bus.mem_data};
            last_grant_q   <= 1'b1;
            write_enable_q <= 1'b1;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          write_enable_q <= 1'b0;
          cnt_q          <= '0;
          state          <= WAIT_DONE;
        end
        WAIT_DONE: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (bus.rf_write_done) begin
            state <= IDLE;
          end else if (cnt_q == CNT_W'(DONE_TIMEOUT - 1)) begin
            // The acknowledge is lost; give up on this write so the port does not deadlock.
            timeout_q <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          write_enable_q <= 1'b0;
          state          <= IDLE;
        end
      endcase
    end
  end

  assign bus.alu_ready       = alu_ready;
  assign bus.mem_ready       = mem_ready;
  assign bus.rf_write_enable = write_enable_q;
  assign bus.rf_store_at     = hold_q.dest;
  assign bus.rf_write_data   = hold_q.data;
  assign bus.busy            = (state != IDLE);
  assign bus.last_grant      = last_grant_q;
  assign bus.timeout_error   = timeout_q;
endmodule
